// File: rtl/mem_arbiter_pkg.sv
// Shared owner and arbiter-state encodings for the RAM arbiter slice.
package mem_arbiter_pkg;

  localparam int unsigned OWN_W = 2;

  typedef enum logic [OWN_W-1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    ARB_RUN    = 2'd0,
    ARB_DRAIN  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rd_track.sv
// Read-owner tracker: shifts the owner of each granted read so it surfaces
// at the head exactly DEPTH cycles later, aligned with the RAM read data.
module arb_rd_track
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e push_id,
  output owner_e head_id,
  output logic   empty
);

  owner_e stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= push_id;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head_id = stage[DEPTH-1];

  always_comb begin
    empty = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (stage[i] != OWN_NONE) empty = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for fetch, load/store and debug with fixed-latency
// read return, fetch starvation guard and an exclusive debug lock.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  input  logic                dbg_lock,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_locked,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             starve_clr;
  owner_e           win, push_id, head_id;
  logic             trk_empty;

  // Next state and winner; reset suppresses every grant.
  always_comb begin
    state_nxt  = state;
    win        = OWN_NONE;
    starve_clr = 1'b0;
    if (!rst) begin
      case (state)
        ARB_RUN: begin
          if (dbg_lock)                                 state_nxt = ARB_DRAIN;
          else if (dbg_req)                             win = OWN_DBG;
          else if (starve_cnt == CNT_W'(STARVE_LIM)) begin
            if (if_req)                                 win = OWN_IF;
            else if (ls_req)                            win = OWN_LS;
          end else if (ls_req)                          win = OWN_LS;
          else if (if_req)                              win = OWN_IF;
        end
        ARB_DRAIN: begin
          if (!dbg_lock)      state_nxt = ARB_RUN;
          else if (trk_empty) state_nxt = ARB_LOCKED;
        end
        ARB_LOCKED: begin
          if (dbg_req) win = OWN_DBG;
          if (!dbg_lock) begin
            state_nxt  = ARB_RUN;
            starve_clr = 1'b1;
          end
        end
        default: state_nxt = ARB_RUN;
      endcase
    end
  end

  // RAM port mux and tracker push for the winning requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    push_id   = OWN_NONE;
    case (win)
      OWN_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        mem_be   = '1;
        push_id  = OWN_IF;
      end
      OWN_LS: begin
        mem_en    = 1'b1;
        mem_we    = ls_we;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        mem_be    = ls_we ? ls_be : {BE_W{1'b1}};
        push_id   = ls_we ? OWN_NONE : OWN_LS;
      end
      OWN_DBG: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_be    = '1;
        push_id   = dbg_we ? OWN_NONE : OWN_DBG;
      end
      default: ;
    endcase
  end

  assign if_gnt  = (win == OWN_IF);
  assign ls_gnt  = (win == OWN_LS);
  assign dbg_gnt = (win == OWN_DBG);

  always_comb begin
    starve_nxt = starve_cnt;
    if (starve_clr || !if_req || if_gnt)         starve_nxt = '0;
    else if (starve_cnt != CNT_W'(STARVE_LIM))   starve_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_RUN;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  arb_rd_track #(.DEPTH(MEM_LAT)) u_track (
    .clk     (clk),
    .rst     (rst),
    .push_id (push_id),
    .head_id (head_id),
    .empty   (trk_empty)
  );

  assign if_rvalid  = (head_id == OWN_IF);
  assign ls_rvalid  = (head_id == OWN_LS);
  assign dbg_rvalid = (head_id == OWN_DBG);
  assign if_rdata   = mem_rdata;
  assign ls_rdata   = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign dbg_locked = (state == ARB_LOCKED);

endmodule
